ifu_bus_if: RTL and testbench
=============================

Name: ifu_bus_if

Overview:
- Instruction-fetch bus master for the IF stage.
- Takes the current word-address PC from the IF/ID pipeline register and runs a request/grant/address-strobe/ready read transaction on the shared bus.
- Returns the fetched instruction word to the IF/ID register and raises `busy`, which the pipeline controller ORs into the IF stall.
- Buffers a returned word while the rest of the pipeline is stalled, and discards in-flight data on a flush.

Parameters:
- `ADDR_W`, 30: word-address width (PC and bus address).
- `DATA_W`, 32: instruction/bus data width.
- `NOP_INSN`, 32'h0000_0000: instruction driven when no valid word is available; set equal to the ISA NOP encoding.
- `TIMEOUT_CYCLES`, 255: ready-wait limit; used only when IFU_BUS_TIMEOUT_EN is defined. Range 1..65535.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `if_pc`  in  ADDR_W  word address to fetch, from the IF/ID register
- `fetch_en`  in  1  fetch permitted (CPU running)
- `stall`  in  1  external pipeline stall; excludes this block's own `busy`
- `flush`  in  1  pipeline flush; discard the current fetch
- `insn`  out  DATA_W  fetched instruction to the IF/ID register
- `busy`  out  1  fetch in progress; IF stage must hold
- `bus_req`  out  1  bus request to the arbiter
- `bus_grant`  in  1  bus grant from the arbiter
- `bus_addr`  out  ADDR_W  registered bus word address
- `bus_as`  out  1  address strobe, one cycle per transaction
- `bus_rw`  out  1  constant 1 (read)
- `bus_rd_data`  in  DATA_W  read data
- `bus_rdy`  in  1  read data valid
- `bus_err`  out  1  timeout pulse; tied 0 without IFU_BUS_TIMEOUT_EN

Behaviour:
- Clocking/reset: one clock domain, `clk`. Reset is synchronous and active-high: sampled only on the rising edge of `clk`.
- Reset values: state=IDLE, `bus_req`=0, `bus_as`=0, `bus_addr`=0, `busy`=0, `insn`=NOP_INSN, `bus_err`=0, data buffer=NOP_INSN, timeout counter=0.
- Reset asserted mid-transaction aborts immediately: `bus_req` drops on the next edge, and a late `bus_rdy` is ignored.

State machine, 4 states:
- IDLE: `busy`=0, `insn`=NOP_INSN.
  - If `fetch_en`=1 && `stall`=0 && `flush`=0: register `bus_addr`<=`if_pc`, `bus_req`<=1, go to REQ.
  - `busy` is asserted combinationally in this same cycle, so the IF/ID register does not advance.
- REQ: `busy`=1, `bus_req`=1.
  - On `bus_grant`=1: `bus_as`<=1 for exactly one cycle, go to ACCESS.
  - If `flush`=1 before grant: drop `bus_req`, return to IDLE, no strobe issued.
- ACCESS: `bus_req` stays 1 and `bus_addr` is held stable until `bus_rdy`.
  - Cycle with `bus_rdy`=1 and `flush`=0: `busy`=0 and `insn`=`bus_rd_data` combinationally, so the IF/ID register captures it on that edge (0 extra latency). Also `bus_req`<=0 and buffer<=`bus_rd_data`. Next state is STALL if `stall`=1, else IDLE.
  - Cycle with `bus_rdy`=1 and `flush`=1: data is discarded, `insn`=NOP_INSN, `busy`=0, next state IDLE.
  - Flush while waiting (`bus_rdy`=0): latch a "discard" flag and keep waiting for `bus_rdy`. The bus transaction is never abandoned mid-cycle. The returned data is dropped and `busy` stays 1 until then.
- STALL: `busy`=0, `insn`=buffer, bus idle.
  - `stall`=0: go to IDLE; the IF/ID register consumes the buffer on that edge.
  - `flush`=1 has priority: go to IDLE, and `insn`=NOP_INSN in that cycle.

Boundary and timing rules:
- Minimum fetch time: grant and ready both at the earliest opportunity gives 3 cycles per word (IDLE -> REQ -> ACCESS with `rdy`).
- `bus_rdy` outside ACCESS is ignored.
- `if_pc` changes after IDLE do not affect an in-flight transaction.
- Only one transaction is ever outstanding; no address pipelining.
- Simultaneous `flush` and `stall`: flush wins.

Optional Feature:
- Macro IFU_BUS_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without `bus_rdy`. When it reaches TIMEOUT_CYCLES:
  - drop `bus_req`;
  - pulse `bus_err`=1 for one cycle;
  - drive `insn`=NOP_INSN with `busy`=0 for that cycle;
  - go to IDLE.
- Undefined: no counter logic; `bus_err` is tied 0; ACCESS waits indefinitely.

Test Plan:
- Reset, then `fetch_en`=1, `if_pc`=30'h100, grant next cycle, `rdy` next with data 32'hDEADBEEF -> `bus_addr`=30'h100, `bus_as` high exactly 1 cycle, `insn`=DEADBEEF with `busy`=0 in the `rdy` cycle, 3 cycles total.
- Grant delayed 4 cycles, `rdy` delayed 5 cycles -> `busy`=1 throughout, `bus_req` held continuously, `bus_addr` stable although `if_pc` changes to 30'h200.
- `rdy` with data 32'h1234_5678 while `stall`=1 for 3 cycles -> `insn`=12345678 held in STALL, `bus_req`=0, no new strobe; IDLE after `stall` drops.
- `flush` asserted 2 cycles into ACCESS, `rdy` 3 cycles later with data 32'hCAFE0000 -> `insn`=NOP_INSN, `busy` released only in the `rdy` cycle, next fetch uses the new `if_pc`.
- `reset` asserted in REQ and in ACCESS -> all outputs at reset values after the edge; a stray `bus_rdy` afterwards produces no `insn` change.
- With IFU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, `rdy` never asserted -> `bus_err` is a 1-cycle pulse exactly 8 ACCESS cycles after the strobe, then `bus_req`=0, state IDLE.

Source files
------------

// File: rtl/ifu_bus_if.sv
// Instruction-fetch bus master: one outstanding read per PC, zero-latency hand-off on ready.
// Optional ready-wait timeout is compiled in with `define IFU_BUS_TIMEOUT_EN.
module ifu_bus_if #(
    parameter int                 ADDR_W         = 30,
    parameter int                 DATA_W         = 32,
    parameter logic [DATA_W-1:0]  NOP_INSN       = '0,
    parameter int                 TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] insn,
    output logic              busy,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as,
    output logic              bus_rw,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACCESS = 2'd2,
        S_STALL  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              discard_q, discard_d;
    logic              busy_c;
    logic [DATA_W-1:0] insn_c;
    logic              err_c;

`ifdef IFU_BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = |32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_as_d   = 1'b0;
        bus_addr_d = bus_addr_q;
        buf_d      = buf_q;
        discard_d  = discard_q;
        busy_c     = 1'b0;
        insn_c     = NOP_INSN;
        err_c      = 1'b0;
`ifdef IFU_BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fetch_en && !stall && !flush) begin
                    busy_c     = 1'b1;
                    bus_addr_d = if_pc;
                    bus_req_d  = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                busy_c = 1'b1;
                if (flush) begin
                    bus_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (bus_grant) begin
                    bus_as_d  = 1'b1;
                    discard_d = 1'b0;
`ifdef IFU_BUS_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus_rdy) begin
                    bus_req_d = 1'b0;
                    discard_d = 1'b0;
                    // A flush seen earlier in this access, or now, kills the returned word.
                    if (flush || discard_q) begin
                        state_d = S_IDLE;
                    end else begin
                        insn_c  = bus_rd_data;
                        buf_d   = bus_rd_data;
                        state_d = stall ? S_STALL : S_IDLE;
                    end
`ifdef IFU_BUS_TIMEOUT_EN
                end else if (cnt_q == TO_LIMIT) begin
                    err_c     = 1'b1;
                    bus_req_d = 1'b0;
                    discard_d = 1'b0;
                    state_d   = S_IDLE;
`endif
                end else begin
                    busy_c = 1'b1;
                    if (flush) begin
                        discard_d = 1'b1;
                    end
`ifdef IFU_BUS_TIMEOUT_EN
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            S_STALL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    insn_c = buf_q;
                    if (!stall) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bus_req_q  <= 1'b0;
            bus_as_q   <= 1'b0;
            bus_addr_q <= '0;
            buf_q      <= NOP_INSN;
            discard_q  <= 1'b0;
`ifdef IFU_BUS_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_as_q   <= bus_as_d;
            bus_addr_q <= bus_addr_d;
            buf_q      <= buf_d;
            discard_q  <= discard_d;
`ifdef IFU_BUS_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign insn     = insn_c;
    assign busy     = busy_c;
    assign bus_req  = bus_req_q;
    assign bus_as   = bus_as_q;
    assign bus_addr = bus_addr_q;
    assign bus_rw   = 1'b1;
`ifdef IFU_BUS_TIMEOUT_EN
    assign bus_err  = err_c;
`else
    assign bus_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_bus_if.sv
// Bench for ifu_bus_if: the bench plays arbiter and memory, and a queue of expected
// instruction words is checked wherever the IF/ID register would capture insn.
module tb_ifu_bus_if;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [DW-1:0] NOP = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] if_pc;
    logic          fetch_en, stall, flush;
    logic [DW-1:0] insn;
    logic          busy, bus_req, bus_grant, bus_as, bus_rw, bus_rdy, bus_err;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_rd_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    ifu_bus_if #(
        .ADDR_W(AW), .DATA_W(DW), .NOP_INSN(NOP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .fetch_en(fetch_en),
        .stall(stall), .flush(flush), .insn(insn), .busy(busy),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_addr(bus_addr),
        .bus_as(bus_as), .bus_rw(bus_rw), .bus_rd_data(bus_rd_data),
        .bus_rdy(bus_rdy), .bus_err(bus_err)
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        fetch_en    = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        bus_grant   = 1'b0;
        bus_rdy     = 1'b0;
        bus_rd_data = $urandom;
    endtask

    task automatic chk_reset_values(input string tag);
        chk_b({tag, "_req"}, bus_req, 1'b0);
        chk_b({tag, "_as"}, bus_as, 1'b0);
        chk_w({tag, "_addr"}, 32'(bus_addr), 32'h0);
        chk_b({tag, "_busy"}, busy, 1'b0);
        chk_w({tag, "_insn"}, insn, NOP);
        chk_b({tag, "_err"}, bus_err, 1'b0);
    endtask

    // One fetch: gd extra REQ cycles before grant, rd ACCESS cycles before ready,
    // flush pulse at ACCESS cycle flush_acc (-1 = none), stall held stall_n cycles from ready.
    task automatic fetch(input logic [AW-1:0] pc, input int gd, input int rd,
                         input logic [DW-1:0] data, input int stall_n_in,
                         input int flush_acc, input bit stall_flush);
        bit drop;
        int stall_n;
        drop    = (flush_acc >= 0);
        stall_n = drop ? 0 : stall_n_in;
        if (!drop) exp_q.push_back(data);

        idle_inputs();
        fetch_en = 1'b1;
        if_pc    = pc;
        sample();
        chk_b("idle_busy", busy, 1'b1);
        chk_b("idle_req", bus_req, 1'b0);
        chk_w("idle_insn", insn, NOP);
        tick();

        for (int i = 0; i <= gd; i++) begin
            if_pc       = AW'($urandom);
            bus_grant   = (i == gd);
            bus_rdy     = 1'($urandom_range(0, 1));
            bus_rd_data = $urandom;
            sample();
            chk_b("req_busy", busy, 1'b1);
            chk_b("req_req", bus_req, 1'b1);
            chk_b("req_as", bus_as, 1'b0);
            chk_w("req_addr", 32'(bus_addr), 32'(pc));
            tick();
        end

        for (int j = 0; j <= rd; j++) begin
            if_pc       = AW'($urandom);
            bus_grant   = 1'($urandom_range(0, 1));
            bus_rdy     = (j == rd);
            bus_rd_data = (j == rd) ? data : $urandom;
            flush       = (j == flush_acc);
            stall       = (j < rd) ? 1'($urandom_range(0, 1)) : (stall_n > 0);
            sample();
            chk_b("acc_req", bus_req, 1'b1);
            chk_b("acc_as", bus_as, (j == 0));
            chk_w("acc_addr", 32'(bus_addr), 32'(pc));
            chk_b("acc_err", bus_err, 1'b0);
            if (j < rd) begin
                chk_b("acc_busy", busy, 1'b1);
            end else begin
                chk_b("rdy_busy", busy, 1'b0);
                if (drop) chk_w("rdy_drop_insn", insn, NOP);
                else if (stall_n == 0) chk_w("rdy_insn", insn, exp_q.pop_front());
                else chk_w("rdy_stall_insn", insn, exp_q[0]);
            end
            tick();
        end

        if (stall_n > 0) begin
            for (int k = 1; k < stall_n; k++) begin
                stall     = 1'b1;
                flush     = 1'b0;
                bus_grant = 1'($urandom_range(0, 1));
                bus_rdy   = 1'($urandom_range(0, 1));
                sample();
                chk_w("stl_insn", insn, exp_q[0]);
                chk_b("stl_busy", busy, 1'b0);
                chk_b("stl_req", bus_req, 1'b0);
                chk_b("stl_as", bus_as, 1'b0);
                tick();
            end
            bus_grant = 1'b0;
            bus_rdy   = 1'b0;
            if (stall_flush) begin
                stall = 1'b1;
                flush = 1'b1;
                sample();
                chk_w("stl_flush_insn", insn, NOP);
                void'(exp_q.pop_front());
            end else begin
                stall = 1'b0;
                flush = 1'b0;
                sample();
                chk_w("stl_out_insn", insn, exp_q.pop_front());
            end
            chk_b("stl_out_busy", busy, 1'b0);
            chk_b("stl_out_req", bus_req, 1'b0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        if_pc = '0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        sample();
        chk_reset_values("rst");
        chk_b("rst_rw", bus_rw, 1'b1);
        tick();

        // Minimum-latency fetch, then slow grant/ready with a moving PC.
        fetch(30'h100, 0, 0, 32'hDEAD_BEEF, 0, -1, 1'b0);
        fetch(30'h180, 4, 5, 32'h0BAD_F00D, 0, -1, 1'b0);
        // Ready while stalled for 3 cycles.
        fetch(30'h0AB, 0, 0, 32'h1234_5678, 3, -1, 1'b0);
        // Flush 2 cycles into ACCESS, ready 3 cycles later; next fetch from the new PC.
        fetch(30'h0CD, 0, 5, 32'hCAFE_0000, 0, 2, 1'b0);
        fetch(30'h200, 1, 1, 32'hA5A5_0001, 0, -1, 1'b0);
        // Flush and stall together in STALL: flush wins.
        fetch(30'h210, 1, 1, 32'h0F0F_0F0F, 2, -1, 1'b1);
        // Flush in the ready cycle itself.
        fetch(30'h220, 0, 2, 32'h7777_8888, 0, 2, 1'b0);

        // Flush before grant: request withdrawn, no strobe.
        idle_inputs();
        fetch_en = 1'b1;
        if_pc    = 30'h300;
        tick();
        fetch_en = 1'b0;
        flush    = 1'b1;
        sample();
        chk_b("rqfl_busy", busy, 1'b1);
        tick();
        idle_inputs();
        bus_grant = 1'b1;
        sample();
        chk_b("rqfl_req", bus_req, 1'b0);
        chk_b("rqfl_busy_after", busy, 1'b0);
        tick();
        idle_inputs();
        sample();
        chk_b("rqfl_as", bus_as, 1'b0);
        tick();

        // Reset while in REQ, with a grant in the reset cycle and a stray ready after it.
        idle_inputs();
        fetch_en = 1'b1;
        if_pc    = 30'h3AA;
        tick();
        reset     = 1'b1;
        fetch_en  = 1'b0;
        bus_grant = 1'b1;
        tick();
        reset       = 1'b0;
        bus_grant   = 1'b0;
        bus_rdy     = 1'b1;
        bus_rd_data = 32'h55AA_55AA;
        sample();
        chk_reset_values("rstreq");
        tick();
        bus_rdy = 1'b0;
        sample();
        chk_b("rstreq_as_late", bus_as, 1'b0);
        chk_w("rstreq_insn_late", insn, NOP);
        tick();

        // Reset while in ACCESS, stray ready afterwards.
        idle_inputs();
        fetch_en = 1'b1;
        if_pc    = 30'h3BB;
        tick();
        fetch_en  = 1'b0;
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        sample();
        chk_b("rstacc_as", bus_as, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        bus_rdy     = 1'b1;
        bus_rd_data = 32'h6666_9999;
        sample();
        chk_reset_values("rstacc");
        tick();
        idle_inputs();
        sample();
        chk_b("rstacc_req_late", bus_req, 1'b0);
        tick();

`ifdef IFU_BUS_TIMEOUT_EN
        // Ready never comes: error pulse exactly TO cycles after the strobe.
        idle_inputs();
        fetch_en = 1'b1;
        if_pc    = 30'h3CC;
        tick();
        fetch_en  = 1'b0;
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        for (int j = 0; j <= TO; j++) begin
            sample();
            chk_b("to_err", bus_err, (j == TO));
            chk_b("to_busy", busy, (j != TO));
            chk_w("to_insn", insn, NOP);
            tick();
        end
        sample();
        chk_b("to_req_drop", bus_req, 1'b0);
        chk_b("to_err_after", bus_err, 1'b0);
        chk_b("to_busy_after", busy, 1'b0);
        tick();
`else
        // Without the timeout the access simply keeps waiting.
        fetch(30'h3CC, 0, 20, 32'hFEED_FACE, 0, -1, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            int rd;
            int fa;
            rd = $urandom_range(0, 6);
            fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rd)) : -1;
            if ($urandom_range(0, 2) == 0) begin
                idle_inputs();
                fetch_en = 1'($urandom_range(0, 1));
                stall    = 1'($urandom_range(0, 1));
                flush    = (fetch_en && !stall) ? 1'b1 : 1'($urandom_range(0, 1));
                if_pc    = AW'($urandom);
                sample();
                chk_b("gap_busy", busy, 1'b0);
                chk_b("gap_req", bus_req, 1'b0);
                chk_w("gap_insn", insn, NOP);
                tick();
            end
            fetch(AW'($urandom), $urandom_range(0, 3), rd, $urandom,
                  $urandom_range(0, 3), fa, ($urandom_range(0, 5) == 0));
        end

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_errors++;
            $error("FAIL sb_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
